// File: rtl/pc_sequencer.sv
// Program counter with stall, branch, jump, call/return and circular return-address stack.
// Latency: a request sampled on a rising edge appears on pc_out after that edge; pc_plus_inc is combinational.
// Backpressure: stall freezes the PC, stack and flags, and that cycle's requests are dropped.
module pc_sequencer #(
    parameter int          PC_WIDTH  = 7,
    parameter int          INC       = 1,
    parameter int          OFF_WIDTH = 7,
    parameter int unsigned RESET_VEC = 0,
    parameter int          RAS_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 stall,
    input  logic                 branch_taken,
    input  logic [OFF_WIDTH-1:0] branch_offset,
    input  logic                 jump,
    input  logic [PC_WIDTH-1:0]  jump_target,
    input  logic                 call,
    input  logic                 ret,
    output logic [PC_WIDTH-1:0]  pc_out,
    output logic [PC_WIDTH-1:0]  pc_plus_inc,
    output logic                 ras_empty,
    output logic                 ras_full,
    output logic                 ras_overflow,
    output logic                 ras_underflow
);

    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PC_WIDTH-1:0] pc_q;
    logic [PC_WIDTH-1:0] ras_mem [RAS_DEPTH];
    logic [PTR_W-1:0]    ptr_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                ovf_q;
    logic                unf_q;

    logic [PTR_W-1:0]    pop_ptr;
    logic [PC_WIDTH-1:0] branch_pc;
    logic                cnt_zero;
    logic                cnt_full;
    logic                do_push;

    // Derived next-PC candidates and stack status; the offset is sign-extended to PC width.
    always_comb begin
        pc_plus_inc = pc_q + PC_WIDTH'(INC);
        branch_pc   = pc_plus_inc + PC_WIDTH'($signed(branch_offset));
        pop_ptr     = ptr_q - PTR_W'(1);
        cnt_zero    = (cnt_q == '0);
        cnt_full    = (cnt_q == CNT_W'(RAS_DEPTH));
        // A ret in the same cycle wins over call, so no push happens then.
        do_push     = !rst && !stall && !ret && call;
    end

    // PC, stack pointer, occupancy and sticky flags, in request priority order.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= PC_WIDTH'(RESET_VEC);
            ptr_q <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else if (!stall) begin
            if (ret) begin
                if (!cnt_zero) begin
                    pc_q  <= ras_mem[pop_ptr];
                    ptr_q <= pop_ptr;
                    cnt_q <= cnt_q - CNT_W'(1);
                end else begin
                    // Nothing to return to: fall through sequentially and remember it.
                    pc_q  <= pc_plus_inc;
                    unf_q <= 1'b1;
                end
            end else if (call) begin
                pc_q  <= jump_target;
                ptr_q <= ptr_q + PTR_W'(1);
                if (cnt_full) begin
                    // Oldest entry was just overwritten; occupancy stays at depth.
                    ovf_q <= 1'b1;
                end else begin
                    cnt_q <= cnt_q + CNT_W'(1);
                end
            end else if (jump) begin
                pc_q <= jump_target;
            end else if (branch_taken) begin
                pc_q <= branch_pc;
            end else begin
                pc_q <= pc_plus_inc;
            end
        end
    end

    // Return-address storage; contents are meaningless until written, so it carries no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            ras_mem[ptr_q] <= pc_plus_inc;
        end
    end

    // Status outputs come straight from registered state.
    always_comb begin
        pc_out        = pc_q;
        ras_empty     = cnt_zero;
        ras_full      = cnt_full;
        ras_overflow  = ovf_q;
        ras_underflow = unf_q;
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed and randomized checks of pc_sequencer against a queue-based reference model.
// Each step drives one cycle of requests, then compares all outputs shortly after the edge.
// Stall and reset are exercised directly and inside the random phase.
module tb_pc_sequencer;

    localparam int PCW   = 7;
    localparam int OFFW  = 7;
    localparam int DEPTH = 4;
    localparam int MODV  = 1 << PCW;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic            stall = 1'b0;
    logic            branch_taken = 1'b0;
    logic [OFFW-1:0] branch_offset = '0;
    logic            jump = 1'b0;
    logic [PCW-1:0]  jump_target = '0;
    logic            call = 1'b0;
    logic            ret = 1'b0;
    logic [PCW-1:0]  pc_out;
    logic [PCW-1:0]  pc_plus_inc;
    logic            ras_empty;
    logic            ras_full;
    logic            ras_overflow;
    logic            ras_underflow;

    int n_assert = 0;
    int n_fail   = 0;

    // Reference model state: PC as an integer, stack as a queue (back = most recent).
    int m_pc  = 0;
    int m_stk[$];
    bit m_ovf = 1'b0;
    bit m_unf = 1'b0;

    pc_sequencer #(
        .PC_WIDTH (PCW),
        .INC      (1),
        .OFF_WIDTH(OFFW),
        .RESET_VEC(0),
        .RAS_DEPTH(DEPTH)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .call         (call),
        .ret          (ret),
        .pc_out       (pc_out),
        .pc_plus_inc  (pc_plus_inc),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full),
        .ras_overflow (ras_overflow),
        .ras_underflow(ras_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Apply one cycle of the architectural rules to the model.
    task automatic model_step();
        int off;
        off = int'(branch_offset);
        if (off >= (1 << (OFFW - 1))) off = off - (1 << OFFW);
        if (rst) begin
            m_pc = 0;
            m_stk.delete();
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else if (stall) begin
            // everything held
        end else if (ret) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin
                m_pc  = (m_pc + 1) % MODV;
                m_unf = 1'b1;
            end
        end else if (call) begin
            m_stk.push_back((m_pc + 1) % MODV);
            if (m_stk.size() > DEPTH) begin
                void'(m_stk.pop_front());
                m_ovf = 1'b1;
            end
            m_pc = int'(jump_target);
        end else if (jump) begin
            m_pc = int'(jump_target);
        end else if (branch_taken) begin
            m_pc = (((m_pc + 1 + off) % MODV) + MODV) % MODV;
        end else begin
            m_pc = (m_pc + 1) % MODV;
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},    int'(pc_out),        m_pc);
        chk({tag, ".pinc"},  int'(pc_plus_inc),   (m_pc + 1) % MODV);
        chk({tag, ".empty"}, int'(ras_empty),     int'(m_stk.size() == 0));
        chk({tag, ".full"},  int'(ras_full),      int'(m_stk.size() == DEPTH));
        chk({tag, ".ovf"},   int'(ras_overflow),  int'(m_ovf));
        chk({tag, ".unf"},   int'(ras_underflow), int'(m_unf));
    endtask

    // One clock of stimulus: drive, clock, update model, compare after the edge.
    task automatic step(input string tag, input bit r, input bit s, input bit br,
                        input int off, input bit j, input int tgt, input bit c, input bit rt);
        rst           = r;
        stall         = s;
        branch_taken  = br;
        branch_offset = OFFW'(off);
        jump          = j;
        jump_target   = PCW'(tgt);
        call          = c;
        ret           = rt;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic go(input int tgt);
        step("jmp", 0, 0, 0, 0, 1, tgt, 0, 0);
    endtask

    initial begin
        @(posedge clk);
        #1;
        // 1. reset and free-run
        step("rst0", 1, 0, 0, 0, 0, 0, 0, 0);
        step("rst1", 1, 0, 0, 0, 0, 0, 0, 0);
        chk("rst_pc", int'(pc_out), 0);
        chk("rst_empty", int'(ras_empty), 1);
        for (int i = 1; i <= 3; i++) begin
            idle("free");
            chk("free_pc", int'(pc_out), i);
        end
        // 2. wrap
        go(126);
        idle("wrap");
        chk("wrap_127", int'(pc_out), 127);
        chk("wrap_pinc", int'(pc_plus_inc), 0);
        idle("wrap");
        chk("wrap_0", int'(pc_out), 0);
        // 3. branches
        go(10);
        step("br", 0, 0, 1, 'h7D, 0, 0, 0, 0);
        chk("br_m3", int'(pc_out), 8);
        go(2);
        step("br", 0, 0, 1, -5, 0, 0, 0, 0);
        chk("br_wrapneg", int'(pc_out), 126);
        go(10);
        step("br", 0, 0, 1, 4, 0, 0, 0, 0);
        chk("br_p4", int'(pc_out), 15);
        // 4. call and return, single and nested
        go(5);
        step("call", 0, 0, 0, 0, 0, 40, 1, 0);
        chk("call_pc", int'(pc_out), 40);
        chk("call_nonempty", int'(ras_empty), 0);
        idle("after_call");
        chk("after_call_pc", int'(pc_out), 41);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ret_pc", int'(pc_out), 6);
        chk("ret_empty", int'(ras_empty), 1);
        go(5);
        step("call", 0, 0, 0, 0, 0, 20, 1, 0);
        step("call", 0, 0, 0, 0, 0, 30, 1, 0);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("nest_ret1", int'(pc_out), 21);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("nest_ret2", int'(pc_out), 6);
        // 5. overflow then underflow
        go(1);
        step("call", 0, 0, 0, 0, 0, 11, 1, 0);
        step("call", 0, 0, 0, 0, 0, 21, 1, 0);
        step("call", 0, 0, 0, 0, 0, 31, 1, 0);
        step("call", 0, 0, 0, 0, 0, 41, 1, 0);
        step("call", 0, 0, 0, 0, 0, 50, 1, 0);
        chk("ovf_full", int'(ras_full), 1);
        chk("ovf_flag", int'(ras_overflow), 1);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_ret42", int'(pc_out), 42);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_ret32", int'(pc_out), 32);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_ret22", int'(pc_out), 22);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("ovf_ret12", int'(pc_out), 12);
        step("ret", 0, 0, 0, 0, 0, 0, 0, 1);
        chk("unf_pc", int'(pc_out), 13);
        chk("unf_flag", int'(ras_underflow), 1);
        idle("sticky");
        chk("sticky_ovf", int'(ras_overflow), 1);
        chk("sticky_unf", int'(ras_underflow), 1);
        // 6. stall, priority, reset
        go(60);
        step("call", 0, 0, 0, 0, 0, 90, 1, 0);
        step("stall", 0, 1, 1, 3, 0, 0, 0, 1);
        chk("stall_pc", int'(pc_out), 90);
        chk("stall_nonempty", int'(ras_empty), 0);
        step("callret", 0, 0, 0, 0, 0, 33, 1, 1);
        chk("callret_pc", int'(pc_out), 61);
        chk("callret_empty", int'(ras_empty), 1);
        step("jmpbr", 0, 0, 1, 5, 1, 70, 0, 0);
        chk("jmpbr_pc", int'(pc_out), 70);
        step("call", 0, 0, 0, 0, 0, 100, 1, 0);
        step("rstcall", 1, 0, 0, 0, 0, 50, 1, 0);
        chk("rst_mid_pc", int'(pc_out), 0);
        chk("rst_mid_empty", int'(ras_empty), 1);
        chk("rst_mid_ovf", int'(ras_overflow), 0);
        chk("rst_mid_unf", int'(ras_underflow), 0);
        // Random phase against the model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 63) == 0),
                 ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 3) == 0),
                 int'($urandom_range(0, MODV - 1)),
                 ($urandom_range(0, 5) == 0),
                 int'($urandom_range(0, MODV - 1)),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 4) == 0));
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
